// File: rtl/slice_logic_pipe.sv
// Two-stage valid/ready pipeline of 4-bit slice logic with per-unit update enables.
// Optional per-unit result parity is built when SLICE_PARITY_EN is defined.
module slice_logic_pipe #(
    parameter int unsigned NUM_UNITS       = 3,
    parameter int unsigned SLICES_PER_UNIT = 3,
    parameter int unsigned CNT_W           = 16,
    localparam int unsigned UW             = 4 * SLICES_PER_UNIT,
    localparam int unsigned W              = UW * NUM_UNITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         A,
    input  logic [W-1:0]         B,
    input  logic [NUM_UNITS-1:0] unit_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         C,
    output logic [NUM_UNITS-1:0] out_parity,
    input  logic                 count_clr,
    output logic [CNT_W-1:0]     txn_count
);

    logic                 s1_valid_q;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [NUM_UNITS-1:0] en_q;
    logic                 out_valid_q;
    logic [W-1:0]         c_q;
    logic [CNT_W-1:0]     txn_q;
    logic                 s2_ready;
    logic [W-1:0]         res;
    logic [W-1:0]         c_d;

    // Stage 2 frees up when empty or draining; stage 1 then always moves on.
    assign s2_ready  = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_ready;
    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign txn_count = txn_q;

    always_comb begin
        res = '0;
        for (int s = 0; s < int'(NUM_UNITS * SLICES_PER_UNIT); s++) begin
            res[4*s]   = ~a_q[4*s];
            res[4*s+1] = ~b_q[4*s];
            res[4*s+2] = ~b_q[4*s+1];
            res[4*s+3] = ~((a_q[4*s+1] | a_q[4*s+2]) & (b_q[4*s+1] | b_q[4*s+2]) &
                           (a_q[4*s+3] | b_q[4*s+3]));
        end
    end

    always_comb begin
        c_d = c_q;
        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            if (en_q[u]) begin
                c_d[UW*u +: UW] = res[UW*u +: UW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            en_q        <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q  <= A;
                    b_q  <= B;
                    en_q <= unit_en;
                end
            end
            if (s2_ready) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    c_q <= c_d;
                end
            end
        end
    end

`ifdef SLICE_PARITY_EN
    logic [NUM_UNITS-1:0] par_q;
    logic [NUM_UNITS-1:0] par_d;

    always_comb begin
        par_d = '0;
        for (int u = 0; u < int'(NUM_UNITS); u++) begin
            par_d[u] = ^c_d[UW*u +: UW];
        end
    end

    // Parity follows C exactly, including disabled-unit hold and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else if (s2_ready && s1_valid_q) begin
            par_q <= par_d;
        end
    end

    assign out_parity = par_q;
`else
    assign out_parity = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q <= '0;
        end else if (count_clr) begin
            txn_q <= '0;
        end else if (out_valid_q && out_ready && (txn_q != {CNT_W{1'b1}})) begin
            txn_q <= txn_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_slice_logic_pipe.sv
// Self-checking bench for slice_logic_pipe: directed vector table, stall/clear/reset
// sequences and randomized traffic against a transaction-level queue model.
module tb_slice_logic_pipe;
    localparam int W  = 36;
    localparam int NU = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          count_clr = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [NU-1:0] unit_en = '0;

    logic          in_ready, out_valid, in_ready2, out_valid2;
    logic [W-1:0]  c, c2;
    logic [NU-1:0] par, par2;
    logic [15:0]   txn;
    logic [3:0]    txn2;

    slice_logic_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
        .unit_en(unit_en), .out_valid(out_valid), .out_ready(out_ready), .C(c),
        .out_parity(par), .count_clr(count_clr), .txn_count(txn)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    slice_logic_pipe #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .A(a), .B(b),
        .unit_en(unit_en), .out_valid(out_valid2), .out_ready(out_ready), .C(c2),
        .out_parity(par2), .count_clr(count_clr), .txn_count(txn2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  c;
        logic [NU-1:0] par;
        int            t;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [NU-1:0] en;
        logic [W-1:0]  c;
        logic [NU-1:0] par;
    } vec_t;

    exp_t         q[$];
    exp_t         shown;
    logic [W-1:0] last_c;
    int           cyc = 0;
    int           n16 = 0;
    int           n4 = 0;
    int           checks = 0;
    int           errors = 0;
    bit           last_xi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NU-1:0] exp_par(input logic [W-1:0] v);
        logic [NU-1:0] p = '0;
`ifdef SLICE_PARITY_EN
        for (int u = 0; u < NU; u++) p[u] = ^v[12*u +: 12];
`else
        p = v[NU-1:0] & '0;
`endif
        return p;
    endfunction

    // Spec rules per nibble; disabled units keep the previously produced result.
    function automatic logic [W-1:0] calc(input logic [W-1:0] va, input logic [W-1:0] vb,
                                          input logic [NU-1:0] en, input logic [W-1:0] prev);
        logic [W-1:0] r;
        for (int s = 0; s < W / 4; s++) begin
            int na = int'(va[4*s +: 4]);
            int nb = int'(vb[4*s +: 4]);
            r[4*s]   = (na % 2) == 0;
            r[4*s+1] = (nb % 2) == 0;
            r[4*s+2] = ((nb / 2) % 2) == 0;
            r[4*s+3] = !(((na & 6) != 0) && ((nb & 6) != 0) && (((na | nb) & 8) != 0));
        end
        for (int u = 0; u < NU; u++) if (!en[u]) r[12*u +: 12] = prev[12*u +: 12];
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        last_c    = '0;
        shown.c   = '0;
        shown.par = '0;
        n16       = 0;
        n4        = 0;
    endtask

    // One clock: check outputs against the model, then advance it across the edge.
    task automatic step();
        bit   ov_e, ir_e, xo;
        exp_t e;
        #1;
        ov_e = (q.size() >= 2) || (q.size() == 1 && cyc >= q[0].t + 1);
        ir_e = (q.size() < 2) || out_ready;
        chk("in_ready", 64'(in_ready), 64'(ir_e));
        chk("out_valid", 64'(out_valid), 64'(ov_e));
        if (ov_e) begin
            chk("C", 64'(c), 64'(q[0].c));
            chk("parity", 64'(par), 64'(q[0].par));
        end else begin
            chk("C_held", 64'(c), 64'(shown.c));
            chk("parity_held", 64'(par), 64'(shown.par));
        end
        chk("txn_count", 64'(txn), 64'(n16));
        chk("txn_count_sat", 64'(txn2), 64'(n4));
        xo      = ov_e && out_ready;
        last_xi = in_valid && ir_e;
        @(posedge clk);
        cyc++;
        if (xo) shown = q.pop_front();
        if (count_clr) begin
            n16 = 0;
            n4  = 0;
        end else if (xo) begin
            n16 = (n16 < 65535) ? n16 + 1 : n16;
            n4  = (n4 < 15) ? n4 + 1 : n4;
        end
        if (last_xi) begin
            e.c   = calc(a, b, unit_en, last_c);
            e.par = exp_par(e.c);
            e.t   = cyc;
            last_c = e.c;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] wa, input logic [W-1:0] wb,
                             input logic [NU-1:0] we);
        a = wa;
        b = wb;
        unit_en = we;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (last_xi) break;
        end
        chk("send_accepted", 64'(last_xi), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    vec_t vecs[4];
    int   sent;
    int   base;

    initial begin
        model_reset();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_C", 64'(c), 64'd0);
        chk("rst_txn", 64'(txn), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{a: '0, b: '0, en: 3'b111, c: 36'hFFFFFFFFF, par: 3'b000};
        vecs[1] = '{a: {W{1'b1}}, b: '0, en: 3'b111, c: 36'hEEEEEEEEE, par: 3'b111};
        vecs[2] = '{a: {W{1'b1}}, b: {W{1'b1}}, en: 3'b111, c: 36'h000000000, par: 3'b000};
        vecs[3] = '{a: '0, b: '0, en: 3'b101, c: 36'hFFF000FFF, par: 3'b000};

        for (int i = 0; i < 4; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            unit_en = vecs[i].en;
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            chk("tbl_out_valid", 64'(out_valid), 64'd1);
            chk("tbl_C", 64'(c), 64'(vecs[i].c));
`ifdef SLICE_PARITY_EN
            chk("tbl_parity", 64'(par), 64'(vecs[i].par));
`else
            chk("tbl_parity_off", 64'(par), 64'd0);
`endif
            step();
            if (i == 0) chk("tbl_txn_first", 64'(txn), 64'd1);
        end

        // Four words against a 5-cycle downstream stall.
        base = 4;
        sent = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = W'({$urandom(), $urandom()});
        b = W'({$urandom(), $urandom()});
        unit_en = 3'($urandom());
        for (int k = 0; k < 40 && sent < 4; k++) begin
            if (k == 5) begin
                chk("stall_accepted", 64'(sent), 64'd2);
                out_ready = 1'b1;
            end
            step();
            if (last_xi) begin
                sent++;
                a = W'({$urandom(), $urandom()});
                b = W'({$urandom(), $urandom()});
                unit_en = 3'($urandom());
            end
        end
        drain();
        chk("stall_txn", 64'(txn), 64'(base + 4));

        // Clear coinciding with an output transfer at count 7.
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            send_word(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 3'b111);
            drain();
        end
        chk("txn_seven", 64'(txn), 64'd7);
        out_ready = 1'b0;
        send_word(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 3'b011);
        step();
        chk("clr_xfer_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        chk("clr_wins", 64'(txn), 64'd0);

        // Saturation on the narrow counter.
        sent = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && sent < 18; k++) begin
            a = W'({$urandom(), $urandom()});
            b = W'({$urandom(), $urandom()});
            unit_en = 3'($urandom());
            step();
            if (last_xi) sent++;
        end
        drain();
        chk("sat_narrow", 64'(txn2), 64'hF);
        chk("sat_wide", 64'(txn), 64'd18);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            count_clr = 1'($urandom_range(0, 40) == 0);
            a = W'({$urandom(), $urandom()});
            b = W'({$urandom(), $urandom()});
            unit_en = 3'($urandom());
            step();
        end
        count_clr = 1'b0;
        drain();

        // Reset with two words in flight.
        out_ready = 1'b0;
        send_word(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 3'b111);
        send_word(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}), 3'b111);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_C", 64'(c), 64'd0);
        chk("midrst_txn", 64'(txn), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        send_word({W{1'b1}}, '0, 3'b111);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/slice_logic_pipe.md
SLICE_LOGIC_PIPE -- requirements
Module: slice_logic_pipe

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 3, meaning the number of independent logic units.
REQ-002 SHALL have parameter SLICES_PER_UNIT, default 3, meaning the number of 4-bit slices per unit; derived W = 4*SLICES_PER_UNIT*NUM_UNITS (default 36).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the transfer counter width.
REQ-004 clk  input  1  the single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  operand word valid.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 A  input  W  operand A.
REQ-009 B  input  W  operand B.
REQ-010 unit_en  input  NUM_UNITS  per-unit update enable, sampled with operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 C  output  W  result word.
REQ-014 out_parity  output  NUM_UNITS  per-unit result parity (see Configuration).
REQ-015 count_clr  input  1  synchronous clear of txn_count.
REQ-016 txn_count  output  CNT_W  number of completed output transfers.

Function
REQ-017 Slice s (a=A[4s+:4], b=B[4s+:4]) SHALL compute r0=~a0, r1=~b0, r2=~b1, r3=~((a1|a2)&(b1|b2)&(a3|b3)); C[4s+:4]=r.
REQ-018 Unit u SHALL own bits [4*SLICES_PER_UNIT*u +: 4*SLICES_PER_UNIT]; unit 0 is LSB.
REQ-019 Two-stage pipeline: stage 1 registers A, B, unit_en; stage 2 registers the computed result; latency from accepted input to out_valid SHALL be exactly 2 cycles with no stalls.
REQ-020 Input transfer occurs when in_valid&in_ready; output transfer when out_valid&out_ready.
REQ-021 in_ready SHALL be 1 when stage 1 is empty, or stage 2 is empty, or out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, C, out_parity and out_valid SHALL hold stable; no accepted word SHALL be dropped or duplicated.
REQ-023 When stage 2 loads, units with captured unit_en[u]=0 SHALL keep their previous C bits; enabled units load new results.
REQ-024 Back-to-back transfers with out_ready=1 SHALL sustain one word per cycle.
REQ-025 txn_count SHALL increment by 1 per output transfer, saturating at all-ones (no wrap).
REQ-026 count_clr SHALL set txn_count to 0 next cycle; clear wins over a simultaneous transfer.

Reset
REQ-027 On rst_n=0, immediately: out_valid=0, both stage valids=0, C=0, out_parity=0, txn_count=0; in_ready=1.
REQ-028 Reset asserted mid-pipeline SHALL discard all in-flight words; first output after release requires a fresh input transfer.

Configuration
REQ-029 Macro SLICE_PARITY_EN defined: out_parity[u] SHALL equal the XOR of unit u's C bits, registered with C and held with C under stall and disabled-unit hold.
REQ-030 SLICE_PARITY_EN undefined: out_parity SHALL be constant 0 and no parity logic SHALL be synthesised.

Verification
REQ-031 Defaults, A=0, B=0, unit_en=3'b111, out_ready=1 -> C=36'hFFFFFFFFF two cycles later, txn_count=1.
REQ-032 A=all ones, B=0, unit_en=3'b111 -> C=36'hEEEEEEEEE; with SLICE_PARITY_EN out_parity=3'b111, without it 3'b000.
REQ-033 After C=36'h000000000 (A=B=all ones), send A=B=0 with unit_en=3'b101 -> C=36'hFFF000FFF.
REQ-034 Send 4 words back-to-back, out_ready=0 for 5 cycles then 1 -> in_ready drops after 2 accepted, C stable while stalled, all 4 words emerge in order, txn_count=4.
REQ-035 Assert count_clr in the same cycle as an output transfer with txn_count=7 -> txn_count=0; preset counter near max, 3 transfers -> saturates at 16'hFFFF.
REQ-036 Drop rst_n with 2 words in flight -> out_valid=0, C=0, txn_count=0 immediately; no stale word after release.
